// File: rtl/cla_pkg.sv
// cla_pkg: shared widths, slice count and FSM encoding for the sequential CLA subtractor
package cla_pkg;
  localparam int W       = 64;
  localparam int SLICE_W = 16;
  localparam int NSL     = W / SLICE_W;
  localparam int CNT_W   = $clog2(NSL);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/cla_slice.sv
// cla_slice: combinational SW-bit two-level carry-lookahead adder (x + y + ci)
// ports: x, y operands; ci carry-in; s sum; co carry-out of bit SW-1
module cla_slice
  import cla_pkg::*;
#(
  parameter int SW = SLICE_W
) (
  input  logic [SW-1:0] x,
  input  logic [SW-1:0] y,
  input  logic          ci,
  output logic [SW-1:0] s,
  output logic          co
);
  localparam int NG = SW / 4;
  logic [SW-1:0] g, p, c;
  logic [NG-1:0] gg, gp;
  logic [NG:0]   gc;
  logic          t;
  assign g = x & y;
  assign p = x ^ y;
  // every carry is a flat sum of products (generate chained through propagates),
  // so nothing ripples from one bit or group to the next
  always_comb begin
    gg = '0;
    gp = '1;
    gc = '0;
    c  = '0;
    t  = 1'b0;
    for (int j = 0; j < NG; j++) begin
      for (int i = 0; i < 4; i++) begin
        t = g[4*j+i];
        for (int k = i + 1; k < 4; k++) t = t & p[4*j+k];
        gg[j] = gg[j] | t;
        gp[j] = gp[j] & p[4*j+i];
      end
    end
    for (int j = 0; j <= NG; j++) begin
      for (int i = 0; i < j; i++) begin
        t = gg[i];
        for (int k = i + 1; k < j; k++) t = t & gp[k];
        gc[j] = gc[j] | t;
      end
      t = ci;
      for (int k = 0; k < j; k++) t = t & gp[k];
      gc[j] = gc[j] | t;
    end
    for (int j = 0; j < NG; j++) begin
      for (int i = 0; i < 4; i++) begin
        for (int m = 0; m < i; m++) begin
          t = g[4*j+m];
          for (int k = m + 1; k < i; k++) t = t & p[4*j+k];
          c[4*j+i] = c[4*j+i] | t;
        end
        t = gc[j];
        for (int k = 0; k < i; k++) t = t & p[4*j+k];
        c[4*j+i] = c[4*j+i] | t;
      end
    end
    s  = p ^ c;
    co = gc[NG];
  end
endmodule

// File: rtl/cla_sub64_seq.sv
// cla_sub64_seq: multi-cycle W-bit subtractor diff = a - b - bin, one SLICE_W slice per clock
// ports: clk, rst_n (async active-low); in_valid/in_ready + a, b, bin operand handshake;
//        out_valid/out_ready result handshake; diff, bout (borrow), ovf (signed), zero
module cla_sub64_seq
  import cla_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         ovf,
  output logic         zero
);
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       a_q, a_d, nb_q, nb_d, diff_q, diff_d;
  logic               carry_q, carry_d, bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [SLICE_W-1:0] xs, ys, s;
  logic               co;
  assign xs = a_q[cnt_q*SLICE_W +: SLICE_W];
  assign ys = nb_q[cnt_q*SLICE_W +: SLICE_W];
  cla_slice #(.SW(SLICE_W)) u_slice (.x(xs), .y(ys), .ci(carry_q), .s(s), .co(co));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    nb_d    = nb_q;
    carry_d = carry_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        nb_d    = ~b;
        carry_d = ~bin;
        cnt_d   = '0;
        state_d = CALC;
      end
      CALC: begin
        diff_d[cnt_q*SLICE_W +: SLICE_W] = s;
        carry_d = co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NSL - 1)) begin
          state_d = DONE;
          bout_d  = ~co;
          // operand signs differ (a vs b, i.e. a equals ~b) and result sign differs from a
          ovf_d   = (a_q[W-1] == nb_q[W-1]) && (s[SLICE_W-1] != a_q[W-1]);
          zero_d  = diff_d == '0;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      nb_q    <= '0;
      carry_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      nb_q    <= nb_d;
      carry_q <= carry_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_cla_sub64_seq.sv
// tb_cla_sub64_seq: directed and randomized self-checking bench for cla_sub64_seq
module tb_cla_sub64_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = '0, b = '0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] diff;
  logic        bout, ovf, zero;
  int          total = 0, bad = 0;

  cla_sub64_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic op(input logic [63:0] ta, input logic [63:0] tb, input logic tbin,
                    input logic [63:0] ed, input logic eb, input logic eo, input logic ez,
                    input int si, input int so);
    int n;
    logic [63:0] held;
    out_ready = 1'b0;
    repeat (si) @(negedge clk);
    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_calc", 64'(in_ready), 64'd0);
    a = ~ta; b = ta; bin = ~tbin;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 64'(n), 64'd4);
    chk("diff", diff, ed);
    chk("flags", {61'd0, bout, ovf, zero}, {61'd0, eb, eo, ez});
    held = diff;
    @(negedge clk);
    in_valid = 1'b0;
    if (so > 0) begin
      repeat (so) @(negedge clk);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_diff", diff, held);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_valid", 64'(out_valid), 64'd0);
    chk("post_in_ready", 64'(in_ready), 64'd1);
    chk("post_diff_held", diff, held);
  endtask

  task automatic rand_op(input logic [63:0] ta, input logic [63:0] tb, input logic tbin);
    logic [64:0] r;
    logic [65:0] sr;
    r  = {1'b0, ta} - {1'b0, tb} - 65'(tbin);
    sr = {{2{ta[63]}}, ta} - {{2{tb[63]}}, tb} - 66'(tbin);
    op(ta, tb, tbin, r[63:0], r[64], sr[64] != sr[63], r[63:0] == 64'd0,
       $urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  initial begin
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_outs", {59'd0, out_valid, bout, ovf, zero}, 64'd0);
    chk("rst_diff", diff, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op(64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0, 0, 0);
    op(64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 0, 0);
    op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1, 0);
    op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEEF, 1'b1, 64'd0, 1'b0, 1'b0, 1'b1, 0, 0);
    op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000,
       1'b1, 1'b1, 1'b0, 0, 10);
    op(64'h0001_0000_0000_0000, 64'd0, 1'b1, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 2, 1);
    // abandon an op with reset while slice 2 is being computed
    @(negedge clk);
    a = 64'hFFFF_0000_FFFF_0000; b = 64'h1111_1111_1111_1111; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_outs", {59'd0, out_valid, bout, ovf, zero}, 64'd0);
    chk("midrst_diff", diff, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op(64'd10, 64'd4, 1'b0, 64'd6, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = (i % 7 == 0) ? ra : {$urandom, $urandom};
      rand_op(ra, rb, 1'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
